// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit queue: FSM encoding,
// handshake levels and a saturating counter helper.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_REQ       = 2'd1,
    ST_WAIT_ACK  = 2'd2,
    ST_WAIT_DONE = 2'd3
  } tx_state_t;

  // ready is high while the UART transmitter can take a character
  localparam logic READY_IDLE  = 1'b1;
  localparam logic READY_BUSY  = 1'b0;
  localparam logic SEND_ASSERT = 1'b1;
  localparam logic SEND_IDLE   = 1'b0;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// Dual-port FIFO storage with registered write and combinational read.
// Pointers wrap naturally because DEPTH is a power of two.
module sync_fifo_mem #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              clr,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;

  // Storage array; no reset, the level count keeps unwritten slots unread
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  // Write/read pointer advance, cleared together on flush
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
    end
  end

  assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/uart_tx_fifo.sv
// Character queue in front of a UART transmitter with a four-state
// request/acknowledge handshake, level flags and a drop counter.
//
// state        | meaning
// ST_IDLE      | no character in flight; pops head when queue non-empty and ready=1
// ST_REQ       | send=1, waiting for the transmitter to drop ready
// ST_WAIT_ACK  | transmitter accepted; one-cycle settle
// ST_WAIT_DONE | waiting for ready to return high (character finished)
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 16,
  parameter int AFULL_LVL = DEPTH - 2
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     char_valid,
  input  logic [DATA_W-1:0]        char_data,
  input  logic                     flush,
  input  logic                     ready,
  output logic                     send,
  output logic [DATA_W-1:0]        datao,
  output logic                     busy,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level,
  output logic [15:0]              drop_cnt
);

  localparam int LW = $clog2(DEPTH) + 1;
  localparam logic [LW-1:0] FULL_L  = LW'(DEPTH);
  localparam logic [LW-1:0] AFULL_L = LW'(AFULL_LVL);

  tx_state_t         state;
  tx_state_t         state_nxt;
  logic              push_ok;
  logic              drop;
  logic              pop;
  logic [DATA_W-1:0] head;
  logic [LW-1:0]     level_nxt;

  // full is the registered flag, so a pop in the same cycle cannot rescue a push
  assign push_ok = char_valid & ~full & ~flush;
  assign drop    = char_valid &  full & ~flush;
  assign pop     = (state == ST_IDLE) & ~empty & (ready == READY_IDLE) & ~flush;

  sync_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk     (clk),
    .rstn    (rstn),
    .clr     (flush),
    .wr_en   (push_ok),
    .wr_data (char_data),
    .rd_en   (pop),
    .rd_data (head)
  );

  // Next queue level from push/pop/flush
  always_comb begin
    level_nxt = level;
    if (flush)                level_nxt = '0;
    else if (push_ok && !pop) level_nxt = level + LW'(1);
    else if (pop && !push_ok) level_nxt = level - LW'(1);
  end

  // Registered level and status flags
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      level <= '0;
      empty <= 1'b1;
      full  <= 1'b0;
      busy  <= 1'b0;
    end else begin
      level <= level_nxt;
      empty <= (level_nxt == '0);
      full  <= (level_nxt == FULL_L);
      busy  <= (level_nxt >= AFULL_L);
    end
  end

  // Saturating count of pushes rejected because the queue was full
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)     drop_cnt <= '0;
    else if (drop) drop_cnt <= sat_inc16(drop_cnt);
  end

  // Output character latch; only loads in IDLE so it is stable while send=1
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)    datao <= '0;
    else if (pop) datao <= head;
  end

  // FSM state register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // FSM next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:      if (pop) state_nxt = ST_REQ;
      ST_REQ:       if (ready == READY_BUSY) state_nxt = ST_WAIT_ACK;
      ST_WAIT_ACK:  state_nxt = ST_WAIT_DONE;
      ST_WAIT_DONE: if (ready == READY_IDLE) state_nxt = ST_IDLE;
      default:      state_nxt = ST_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    send = SEND_IDLE;
    if (state == ST_REQ) send = SEND_ASSERT;
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: randomized characters checked
// against a queue-based reference of accepted characters and level rules.
module tb_uart_tx_fifo;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        char_valid = 1'b0;
  logic [7:0]  char_data = 8'h00;
  logic        flush = 1'b0;
  logic        ready_man = 1'b0;
  logic        ready_model = 1'b1;
  logic        tx_auto = 1'b0;
  logic        ready;
  logic        send;
  logic [7:0]  datao;
  logic        busy;
  logic        full;
  logic        empty;
  logic [4:0]  level;
  logic [15:0] drop_cnt;

  int vectors = 0;
  int miscompares = 0;
  int exp_drop = 0;

  logic [7:0] obs_q[$];
  logic [7:0] fill_q[$];
  logic [7:0] exp_q[$];
  int cyc = 0;
  int last_rise = -1;
  int min_gap = 1000;
  int unstable = 0;
  logic send_q = 1'b0;
  logic [7:0] datao_q = 8'h00;

  assign ready = tx_auto ? ready_model : ready_man;

  always #5 clk = ~clk;

  uart_tx_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .char_valid (char_valid),
    .char_data  (char_data),
    .flush      (flush),
    .ready      (ready),
    .send       (send),
    .datao      (datao),
    .busy       (busy),
    .full       (full),
    .empty      (empty),
    .level      (level),
    .drop_cnt   (drop_cnt)
  );

  // Monitor: records the character at every send rising edge
  initial forever begin
    @(posedge clk); #1;
    cyc++;
    if (send && !send_q) begin
      obs_q.push_back(datao);
      if (last_rise >= 0 && (cyc - last_rise) < min_gap) min_gap = cyc - last_rise;
      last_rise = cyc;
    end
    if (send && send_q && datao !== datao_q) unstable++;
    send_q  = send;
    datao_q = datao;
  end

  // Transmitter model: drops ready two cycles after send, busy 1..3 cycles
  initial forever begin
    @(posedge clk); #3;
    if (tx_auto && send) begin
      repeat (2) @(posedge clk);
      #3 ready_model = 1'b0;
      repeat ($urandom_range(1, 3)) @(posedge clk);
      #3 ready_model = 1'b1;
    end
  end

  task automatic step();
    @(posedge clk); #2;
  endtask

  task automatic drain(input int n, input int budget, input string name);
    int t = 0;
    while (!(obs_q.size() == n && empty && !send) && t < budget) begin
      step();
      t++;
    end
    vectors++;
    if (t >= budget) begin
      miscompares++;
      $display("FAIL %s_timeout: got %0d sends expected %0d", name, obs_q.size(), n);
    end
    repeat (10) step();
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) step();
    vectors++; if (send !== 1'b0)      begin miscompares++; $display("FAIL reset_send: got %0b expected 0", send); end
    vectors++; if (datao !== 8'h00)    begin miscompares++; $display("FAIL reset_datao: got %h expected 00", datao); end
    vectors++; if (level !== 5'd0)     begin miscompares++; $display("FAIL reset_level: got %0d expected 0", level); end
    vectors++; if (empty !== 1'b1)     begin miscompares++; $display("FAIL reset_empty: got %0b expected 1", empty); end
    vectors++; if (full !== 1'b0)      begin miscompares++; $display("FAIL reset_full: got %0b expected 0", full); end
    vectors++; if (busy !== 1'b0)      begin miscompares++; $display("FAIL reset_busy: got %0b expected 0", busy); end
    vectors++; if (drop_cnt !== 16'd0) begin miscompares++; $display("FAIL reset_drop: got %0d expected 0", drop_cnt); end
    rstn = 1'b1;
    exp_drop = 0;
    step();
  endtask

  task automatic test_abc();
    logic [7:0] exp [3];
    exp[0] = 8'h41; exp[1] = 8'h42; exp[2] = 8'h43;
    tx_auto = 1'b1;
    obs_q.delete();
    for (int i = 0; i < 3; i++) begin
      char_valid = 1'b1;
      char_data  = exp[i];
      step();
    end
    char_valid = 1'b0;
    drain(3, 300, "abc");
    vectors++; if (obs_q.size() != 3) begin miscompares++; $display("FAIL abc_count: got %0d expected 3", obs_q.size()); end
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (obs_q[i] !== exp[i]) begin miscompares++; $display("FAIL abc_char%0d: got %h expected %h", i, obs_q[i], exp[i]); end
    end
    vectors++; if (empty !== 1'b1) begin miscompares++; $display("FAIL abc_empty: got %0b expected 1", empty); end
  endtask

  task automatic test_fill();
    logic [7:0] d;
    int exp_lvl;
    tx_auto = 1'b0;
    ready_man = 1'b0;
    step();
    fill_q.delete();
    for (int i = 1; i <= 18; i++) begin
      d = 8'($urandom);
      char_valid = 1'b1;
      char_data  = d;
      if (i <= DEPTH) fill_q.push_back(d);
      else            exp_drop++;
      step();
      exp_lvl = (i > DEPTH) ? DEPTH : i;
      vectors++; if (level !== 5'(exp_lvl)) begin miscompares++; $display("FAIL fill_level%0d: got %0d expected %0d", i, level, exp_lvl); end
      vectors++; if (full !== (exp_lvl == DEPTH)) begin miscompares++; $display("FAIL fill_full%0d: got %0b expected %0b", i, full, exp_lvl == DEPTH); end
      vectors++; if (busy !== (exp_lvl >= DEPTH - 2)) begin miscompares++; $display("FAIL fill_busy%0d: got %0b expected %0b", i, busy, exp_lvl >= DEPTH - 2); end
      vectors++; if (empty !== 1'b0) begin miscompares++; $display("FAIL fill_empty%0d: got %0b expected 0", i, empty); end
      vectors++; if (drop_cnt !== 16'(exp_drop)) begin miscompares++; $display("FAIL fill_drop%0d: got %0d expected %0d", i, drop_cnt, exp_drop); end
    end
    char_valid = 1'b0;
  endtask

  task automatic test_full_pop();
    obs_q.delete();
    char_valid = 1'b1;
    char_data  = 8'($urandom);
    ready_man  = 1'b1;
    step();
    char_valid = 1'b0;
    exp_drop++;
    vectors++; if (level !== 5'd15) begin miscompares++; $display("FAIL fullpop_level: got %0d expected 15", level); end
    vectors++; if (drop_cnt !== 16'(exp_drop)) begin miscompares++; $display("FAIL fullpop_drop: got %0d expected %0d", drop_cnt, exp_drop); end
    vectors++; if (full !== 1'b0) begin miscompares++; $display("FAIL fullpop_full: got %0b expected 0", full); end
    tx_auto = 1'b1;
    drain(DEPTH, 600, "fullpop");
    for (int i = 0; i < DEPTH; i++) begin
      vectors++;
      if (obs_q[i] !== fill_q[i]) begin miscompares++; $display("FAIL fullpop_char%0d: got %h expected %h", i, obs_q[i], fill_q[i]); end
    end
    vectors++; if (unstable != 0) begin miscompares++; $display("FAIL fullpop_stable: got %0d changes expected 0", unstable); end
  endtask

  task automatic test_wrap();
    logic [7:0] d;
    int n = 0;
    tx_auto = 1'b1;
    obs_q.delete();
    exp_q.delete();
    min_gap = 1000;
    last_rise = -1;
    for (int c = 0; c < 3000 && n < 40; c++) begin
      if (!full && $urandom_range(0, 3) != 0) begin
        d = 8'($urandom);
        char_valid = 1'b1;
        char_data  = d;
        exp_q.push_back(d);
        n++;
      end else begin
        char_valid = 1'b0;
      end
      step();
    end
    char_valid = 1'b0;
    vectors++; if (n != 40) begin miscompares++; $display("FAIL wrap_pushes: got %0d expected 40", n); end
    drain(40, 2000, "wrap");
    for (int i = 0; i < 40; i++) begin
      vectors++;
      if (obs_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL wrap_char%0d: got %h expected %h", i, obs_q[i], exp_q[i]); end
    end
    vectors++; if (drop_cnt !== 16'(exp_drop)) begin miscompares++; $display("FAIL wrap_drop: got %0d expected %0d", drop_cnt, exp_drop); end
    vectors++; if (min_gap < 4) begin miscompares++; $display("FAIL wrap_gap: got %0d expected >= 4", min_gap); end
    vectors++; if (unstable != 0) begin miscompares++; $display("FAIL wrap_stable: got %0d changes expected 0", unstable); end
  endtask

  task automatic test_flush();
    logic [7:0] d [5];
    tx_auto = 1'b0;
    ready_man = 1'b0;
    step();
    obs_q.delete();
    for (int i = 0; i < 5; i++) begin
      d[i] = 8'($urandom);
      char_valid = 1'b1;
      char_data  = d[i];
      step();
    end
    char_valid = 1'b0;
    vectors++; if (level !== 5'd5) begin miscompares++; $display("FAIL flush_level5: got %0d expected 5", level); end
    ready_man = 1'b1;
    step();
    vectors++; if (send !== 1'b1) begin miscompares++; $display("FAIL flush_req: got %0b expected 1", send); end
    vectors++; if (level !== 5'd4) begin miscompares++; $display("FAIL flush_level4: got %0d expected 4", level); end
    flush = 1'b1;
    char_valid = 1'b1;
    char_data = 8'($urandom);
    step();
    flush = 1'b0;
    char_valid = 1'b0;
    vectors++; if (level !== 5'd0) begin miscompares++; $display("FAIL flush_level0: got %0d expected 0", level); end
    vectors++; if (empty !== 1'b1) begin miscompares++; $display("FAIL flush_empty: got %0b expected 1", empty); end
    vectors++; if (drop_cnt !== 16'(exp_drop)) begin miscompares++; $display("FAIL flush_drop: got %0d expected %0d", drop_cnt, exp_drop); end
    vectors++; if (send !== 1'b1) begin miscompares++; $display("FAIL flush_hold: got %0b expected 1", send); end
    vectors++; if (datao !== d[0]) begin miscompares++; $display("FAIL flush_datao: got %h expected %h", datao, d[0]); end
    ready_man = 1'b0;
    step();
    vectors++; if (send !== 1'b0) begin miscompares++; $display("FAIL flush_ack: got %0b expected 0", send); end
    ready_man = 1'b1;
    repeat (25) step();
    vectors++; if (obs_q.size() != 1) begin miscompares++; $display("FAIL flush_sends: got %0d expected 1", obs_q.size()); end
    vectors++; if (obs_q[0] !== d[0]) begin miscompares++; $display("FAIL flush_char: got %h expected %h", obs_q[0], d[0]); end
  endtask

  task automatic test_reset_mid();
    tx_auto = 1'b0;
    ready_man = 1'b0;
    step();
    obs_q.delete();
    for (int i = 0; i < 3; i++) begin
      char_valid = 1'b1;
      char_data  = 8'($urandom);
      step();
    end
    char_valid = 1'b0;
    ready_man = 1'b1;
    step();
    vectors++; if (send !== 1'b1) begin miscompares++; $display("FAIL rstmid_req: got %0b expected 1", send); end
    ready_man = 1'b0;
    step();
    step();
    vectors++; if (send !== 1'b0) begin miscompares++; $display("FAIL rstmid_wait: got %0b expected 0", send); end
    vectors++; if (level !== 5'd2) begin miscompares++; $display("FAIL rstmid_level2: got %0d expected 2", level); end
    vectors++; if (drop_cnt !== 16'(exp_drop)) begin miscompares++; $display("FAIL rstmid_drop_pre: got %0d expected %0d", drop_cnt, exp_drop); end
    #1 rstn = 1'b0;
    #1;
    exp_drop = 0;
    vectors++; if (send !== 1'b0)      begin miscompares++; $display("FAIL rstmid_send: got %0b expected 0", send); end
    vectors++; if (level !== 5'd0)     begin miscompares++; $display("FAIL rstmid_level: got %0d expected 0", level); end
    vectors++; if (drop_cnt !== 16'd0) begin miscompares++; $display("FAIL rstmid_drop: got %0d expected 0", drop_cnt); end
    vectors++; if (empty !== 1'b1)     begin miscompares++; $display("FAIL rstmid_empty: got %0b expected 1", empty); end
    vectors++; if (datao !== 8'h00)    begin miscompares++; $display("FAIL rstmid_datao: got %h expected 00", datao); end
    step();
    rstn = 1'b1;
    ready_man = 1'b1;
    obs_q.delete();
    repeat (25) step();
    vectors++; if (obs_q.size() != 0) begin miscompares++; $display("FAIL rstmid_nosend: got %0d sends expected 0", obs_q.size()); end
    vectors++; if (level !== 5'd0) begin miscompares++; $display("FAIL rstmid_level_post: got %0d expected 0", level); end
  endtask

  initial begin
    test_reset();
    test_abc();
    test_fill();
    test_full_pop();
    test_wrap();
    test_flush();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 SHALL have parameter DATA_W, default 8, character width in bits.
REQ-002 SHALL have parameter DEPTH, default 16, FIFO entries; power of two, 2..256.
REQ-003 SHALL have parameter AFULL_LVL, default DEPTH-2, level at or above which busy asserts.
REQ-004 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port rstn  input  1  asynchronous active-low reset.
REQ-006 SHALL have port char_valid  input  1  push request, one character per high cycle.
REQ-007 SHALL have port char_data  input  DATA_W  character to push.
REQ-008 SHALL have port flush  input  1  synchronous clear of queued entries.
REQ-009 SHALL have port ready  input  1  UART transmitter idle; synchronous to clk.
REQ-010 SHALL have port send  output  1  transmit request to UART transmitter.
REQ-011 SHALL have port datao  output  DATA_W  character under transmission; stable while send=1.
REQ-012 SHALL have port busy  output  1  level >= AFULL_LVL.
REQ-013 SHALL have port full  output  1  level == DEPTH.
REQ-014 SHALL have port empty  output  1  level == 0.
REQ-015 SHALL have port level  output  clog2(DEPTH)+1  queued entry count.
REQ-016 SHALL have port drop_cnt  output  16  rejected pushes, saturating.

Function
REQ-017 Push SHALL write char_data at the write pointer when char_valid=1 and full=0; level increments next cycle.
REQ-018 Push with full=1 SHALL be discarded and drop_cnt SHALL increment, saturating at 16'hFFFF.
REQ-019 full SHALL be evaluated from registered level; a push in a full cycle SHALL be dropped even if a pop occurs that cycle.
REQ-020 Simultaneous accepted push and pop SHALL leave level unchanged.
REQ-021 Pointers SHALL be clog2(DEPTH) bits and wrap DEPTH-1 -> 0 without gap.
REQ-022 Transmit FSM SHALL have states IDLE, REQ, WAIT_ACK, WAIT_DONE.
REQ-023 IDLE -> REQ when empty=0 and ready=1: pop head into datao, advance read pointer, assert send next cycle.
REQ-024 REQ SHALL hold send=1 until ready=0 observed, then go WAIT_ACK with send=0.
REQ-025 WAIT_ACK SHALL go WAIT_DONE immediately next cycle; WAIT_DONE SHALL return to IDLE when ready=1.
REQ-026 Back-to-back characters SHALL have minimum 4 clk between successive send rising edges.
REQ-027 flush SHALL zero level and both pointers next cycle; character already in datao SHALL complete its handshake.
REQ-028 flush and char_valid in same cycle: flush wins, push discarded, drop_cnt unchanged.
REQ-029 busy, full, empty, level SHALL be registered, updated the cycle after the causing event.

Reset
REQ-030 rstn=0 SHALL asynchronously force: FSM IDLE, send=0, datao=0, level=0, empty=1, full=0, busy=0, drop_cnt=0, pointers=0.
REQ-031 Reset mid-handshake SHALL abandon the in-flight character; no send after release until a new push.
REQ-032 Storage array SHALL NOT need reset; reads of unwritten entries SHALL never reach datao.

Structure
REQ-033 FSM state encoding and UART handshake constants SHALL reside in shared package uart_pkg.
REQ-034 Storage and pointers SHALL be one sub-module sync_fifo_mem (dual-port, registered write, combinational read); FSM and counters in uart_tx_fifo.

Verification
REQ-035 Push 'A','B','C' with ready=1 and transmitter model dropping ready 2 cycles after send -> datao 8'h41,8'h42,8'h43 in order, one send per char, empty=1 at end.
REQ-036 DEPTH=16, ready=0, push 18 chars -> full=1 after 16, drop_cnt=2, busy=1 from level 14.
REQ-037 Full FIFO, push and ready rise same cycle -> push dropped, drop_cnt+1, level 15 after pop.
REQ-038 Push 40 chars continuously draining -> pointers wrap twice, output order identical to input.
REQ-039 Queue 5 chars, flush while REQ -> current char completes, level=0 next cycle, no further send.
REQ-040 rstn low during WAIT_DONE -> send=0, level=0, drop_cnt=0 immediately; no send after release with char_valid=0.
